// File: rtl/lsu_dmem_if_if.sv
// lsu_dmem_if_if: core request/response and data-memory signals of the load/store stage.
// The master side is the core and SRAM wrapper; the slave side is the lsu_dmem_if stage.
interface lsu_dmem_if_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wr_data;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rd_data;
  logic        o_rsp_err;
  logic [31:0] o_data_addr;
  logic [31:0] o_data_wr_data;
  logic [3:0]  o_data_size;
  logic        o_data_write;
  logic        o_data_read;
  logic [31:0] i_data_rd_data;
  modport master (
    output i_req_valid, i_req_write, i_req_funct3, i_req_addr, i_req_wr_data, i_data_rd_data,
    input  o_req_ready, o_rsp_valid, o_rsp_rd_data, o_rsp_err,
    input  o_data_addr, o_data_wr_data, o_data_size, o_data_write, o_data_read
  );
  modport slave (
    input  i_req_valid, i_req_write, i_req_funct3, i_req_addr, i_req_wr_data, i_data_rd_data,
    output o_req_ready, o_rsp_valid, o_rsp_rd_data, o_rsp_err,
    output o_data_addr, o_data_wr_data, o_data_size, o_data_write, o_data_read
  );
endinterface

// File: rtl/lsu_dmem_if.sv
// lsu_dmem_if: single-outstanding load/store stage in front of the data SRAM wrapper.
// LSU_RSP_REG_EN adds a RESP2 state so the response comes straight from flops, one cycle later.
module lsu_dmem_if #(
  parameter int MEM_ADDR_WIDTH = 12
) (
  input logic         i_clk,
  input logic         i_rst_n,
  lsu_dmem_if_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2, RESP2 = 2'd3;
`ifdef LSU_RSP_REG_EN
  localparam bit RSP_REG = 1'b1;
`else
  localparam bit RSP_REG = 1'b0;
`endif
  logic [1:0]  state_q, state_d;
  logic        write_q, err_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic        req_err, issue, wr_issue;
  logic [3:0]  mask;
  logic [31:0] wr_rep, lane, ld_data, rsp_data;
  logic [2:0]  f3;
  logic [31:0] ra;
  assign f3 = bus.i_req_funct3;
  assign ra = bus.i_req_addr;
  // Unsupported funct3 (011/110/111) are folded into the error path.
  assign req_err = (f3 == 3'b011) || (f3[2:1] == 2'b11) ||
                   (f3[1:0] == 2'b01 && ra[0]) || (f3[1:0] == 2'b10 && |ra[1:0]) ||
                   |ra[31:MEM_ADDR_WIDTH];
  always_comb begin
    state_d = state_q == IDLE  ? (bus.i_req_valid ? (req_err ? RESP : ISSUE) : IDLE) :
              state_q == ISSUE ? RESP :
              (state_q == RESP && RSP_REG) ? RESP2 : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= 32'b0;
      wdata_q  <= 32'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.i_req_valid) begin
        write_q  <= bus.i_req_write;
        err_q    <= req_err;
        funct3_q <= f3;
        addr_q   <= ra;
        wdata_q  <= bus.i_req_wr_data;
      end
    end
  end
  assign issue    = state_q == ISSUE;
  assign wr_issue = issue && write_q;
  always_comb begin
    mask   = funct3_q[1] ? 4'b1111 :
             funct3_q[0] ? (4'b0011 << {addr_q[1], 1'b0}) : (4'b0001 << addr_q[1:0]);
    wr_rep = funct3_q[1] ? wdata_q :
             funct3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    lane   = bus.i_data_rd_data >> {addr_q[1:0], 3'b000};
    // funct3[2] selects zero-extension (BU/HU).
    ld_data = funct3_q[1] ? lane :
              funct3_q[0] ? {{16{~funct3_q[2] & lane[15]}}, lane[15:0]} :
                            {{24{~funct3_q[2] & lane[7]}}, lane[7:0]};
    rsp_data = (write_q || err_q) ? 32'b0 : ld_data;
  end
  assign bus.o_req_ready    = state_q == IDLE;
  assign bus.o_data_write   = wr_issue;
  assign bus.o_data_read    = ~wr_issue;
  assign bus.o_data_size    = issue ? mask : 4'b0;
  assign bus.o_data_addr    = issue ? {addr_q[31:2], 2'b00} : 32'b0;
  assign bus.o_data_wr_data = wr_issue ? wr_rep : 32'b0;
`ifdef LSU_RSP_REG_EN
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_data_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'b0;
    end else begin
      rsp_valid_q <= state_q == RESP;
      rsp_err_q   <= state_q == RESP && err_q;
      rsp_data_q  <= state_q == RESP ? rsp_data : 32'b0;
    end
  end
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_err     = rsp_err_q;
  assign bus.o_rsp_rd_data = rsp_data_q;
`else
  assign bus.o_rsp_valid   = state_q == RESP;
  assign bus.o_rsp_err     = state_q == RESP && err_q;
  assign bus.o_rsp_rd_data = state_q == RESP ? rsp_data : 32'b0;
`endif
endmodule

// File: tb/tb_lsu_dmem_if.sv
// tb_lsu_dmem_if: directed vectors for lsu_dmem_if with hand-computed expectations.
// Honours LSU_RSP_REG_EN by adding one cycle of response latency.
module tb_lsu_dmem_if;
`ifdef LSU_RSP_REG_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  lsu_dmem_if_if bus ();
  lsu_dmem_if #(.MEM_ADDR_WIDTH(12)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask
  task automatic idle_outs(input string tag);
    check({tag, "_wr"}, 32'(bus.o_data_write), 0);
    check({tag, "_rd"}, 32'(bus.o_data_read), 1);
    check({tag, "_sz"}, 32'(bus.o_data_size), 0);
  endtask
  task automatic run(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] mem, input logic err,
                     input logic [3:0] sz, input logic [31:0] ewd, input logic [31:0] erd);
    @(negedge clk);
    check({tag, "_ready"}, 32'(bus.o_req_ready), 1);
    bus.i_req_valid = 1'b1;
    bus.i_req_write = w;
    bus.i_req_funct3 = f3;
    bus.i_req_addr = a;
    bus.i_req_wr_data = wd;
    bus.i_data_rd_data = mem;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    check({tag, "_ready1"}, 32'(bus.o_req_ready), 0);
    if (!err) begin
      check({tag, "_iwr"}, 32'(bus.o_data_write), 32'(w));
      check({tag, "_ird"}, 32'(bus.o_data_read), 32'(!w));
      check({tag, "_isz"}, 32'(bus.o_data_size), 32'(sz));
      check({tag, "_iaddr"}, bus.o_data_addr, {a[31:2], 2'b00});
      if (w) check({tag, "_iwd"}, bus.o_data_wr_data, ewd);
      check({tag, "_ival"}, 32'(bus.o_rsp_valid), 0);
      @(negedge clk);
    end else begin
      idle_outs({tag, "_e"});
    end
    for (int i = 0; i < XL; i++) begin
      check({tag, "_early"}, 32'(bus.o_rsp_valid), 0);
      @(negedge clk);
    end
    check({tag, "_val"}, 32'(bus.o_rsp_valid), 1);
    check({tag, "_err"}, 32'(bus.o_rsp_err), 32'(err));
    check({tag, "_data"}, bus.o_rsp_rd_data, erd);
    idle_outs({tag, "_r"});
    @(negedge clk);
    check({tag, "_after"}, 32'(bus.o_rsp_valid), 0);
  endtask
  initial begin
    int acc;
    int rsp;
    bus.i_req_valid = 1'b0;
    bus.i_req_write = 1'b0;
    bus.i_req_funct3 = 3'b0;
    bus.i_req_addr = 32'b0;
    bus.i_req_wr_data = 32'b0;
    bus.i_data_rd_data = 32'b0;
    #12;
    check("rst_ready", 32'(bus.o_req_ready), 1);
    check("rst_val", 32'(bus.o_rsp_valid), 0);
    check("rst_err", 32'(bus.o_rsp_err), 0);
    check("rst_data", bus.o_rsp_rd_data, 0);
    check("rst_addr", bus.o_data_addr, 0);
    check("rst_wd", bus.o_data_wr_data, 0);
    idle_outs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    run("sw",    1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 4'b1111, 32'hDEADBEEF, 0);
    run("sb",    1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 4'b1000, 32'hA5A5A5A5, 0);
    run("sh",    1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 4'b1100, 32'hABCDABCD, 0);
    run("lb",    0, 3'b000, 32'h202, 0, 32'h12F45678, 0, 4'b0100, 0, 32'hFFFFFFF4);
    run("lbu",   0, 3'b100, 32'h202, 0, 32'h12F45678, 0, 4'b0100, 0, 32'h000000F4);
    run("lh",    0, 3'b001, 32'h202, 0, 32'h12F45678, 0, 4'b1100, 0, 32'h000012F4);
    run("lh0",   0, 3'b001, 32'h200, 0, 32'h12F48765, 0, 4'b0011, 0, 32'hFFFF8765);
    run("lhu0",  0, 3'b101, 32'h200, 0, 32'h12F48765, 0, 4'b0011, 0, 32'h00008765);
    run("lb1",   0, 3'b000, 32'h201, 0, 32'h12F48765, 0, 4'b0010, 0, 32'hFFFFFF87);
    run("lw",    0, 3'b010, 32'h104, 0, 32'h12F45678, 0, 4'b1111, 0, 32'h12F45678);
    run("lwmis", 0, 3'b010, 32'h102, 0, 32'h12F45678, 1, 0, 0, 0);
    run("lwoor", 0, 3'b010, 32'h1000, 0, 32'h12F45678, 1, 0, 0, 0);
    run("lhmis", 0, 3'b001, 32'h201, 0, 32'h12F45678, 1, 0, 0, 0);
    run("f3bad", 0, 3'b011, 32'h200, 0, 32'h12F45678, 1, 0, 0, 0);
    run("swmis", 1, 3'b010, 32'h101, 32'h11111111, 0, 1, 0, 0, 0);
    run("sbmax", 1, 3'b000, 32'hFFF, 32'h0000003C, 0, 0, 4'b1000, 32'h3C3C3C3C, 0);
    // back-to-back: request held valid for 6 cycles
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_write = 1'b0;
    bus.i_req_funct3 = 3'b010;
    bus.i_req_addr = 32'h300;
    bus.i_data_rd_data = 32'hCAFEF00D;
    acc = 0;
    rsp = 0;
    for (int i = 0; i < 6; i++) begin
      check("b2b_ready", 32'(bus.o_req_ready), 32'((i % (3 + XL)) == 0));
      if (bus.o_req_ready) acc++;
      if (bus.o_rsp_valid) begin
        rsp++;
        check("b2b_data", bus.o_rsp_rd_data, 32'hCAFEF00D);
      end
      if (i == 5) bus.i_req_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_acc", acc, XL ? 2 : 2);
    check("b2b_rsp", rsp, XL ? 1 : 2);
    repeat (4) @(negedge clk);
    check("b2b_idle", 32'(bus.o_req_ready), 1);
    // reset pulse during ISSUE of a store
    bus.i_req_valid = 1'b1;
    bus.i_req_write = 1'b1;
    bus.i_req_funct3 = 3'b010;
    bus.i_req_addr = 32'h40;
    bus.i_req_wr_data = 32'h55AA55AA;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    check("rsti_wr", 32'(bus.o_data_write), 1);
    rst_n = 1'b0;
    #1;
    check("rsti_wr0", 32'(bus.o_data_write), 0);
    check("rsti_ready", 32'(bus.o_req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("rsti_noval", 32'(bus.o_rsp_valid), 0);
      check("rsti_nowr", 32'(bus.o_data_write), 0);
      check("rsti_rdy", 32'(bus.o_req_ready), 1);
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_dmem_if.md
Name: lsu_dmem_if

Overview:
- Load/store interface stage sitting directly upstream of the data-memory SRAM wrapper; it consumes core load/store requests and produces the SRAM-side address, byte-enable and write-data signals.
- Registers each request, generates the per-byte write mask, replicates store data across lanes, and extracts and sign/zero-extends load data returned one cycle after issue.
- Detects misaligned and out-of-range accesses and suppresses the memory access for them.
- Single outstanding request, no pipelining: a fixed 3-state FSM.

Parameters:
- MEM_ADDR_WIDTH, 12, byte-address width of the data memory. Accesses with addr[31:MEM_ADDR_WIDTH] != 0 are out of range.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_req_valid  input  1  core request valid
- o_req_ready  output  1  block can accept a request (high only in IDLE)
- i_req_write  input  1  1 = store, 0 = load
- i_req_funct3  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_req_addr  input  32  byte address
- i_req_wr_data  input  32  store data, LSB-aligned
- o_rsp_valid  output  1  one-cycle response strobe (loads and stores)
- o_rsp_rd_data  output  32  extended load data; 0 for stores and errors
- o_rsp_err  output  1  valid with o_rsp_valid: misaligned or out-of-range
- o_data_addr  output  32  memory byte address, word-aligned (bits [1:0] = 0)
- o_data_wr_data  output  32  lane-replicated store data
- o_data_size  output  4  byte-lane mask
- o_data_write  output  1  write strobe
- o_data_read  output  1  read enable; also the active-low global write gate, so it must be 0 whenever o_data_write = 1
- i_data_rd_data  input  32  memory read word, valid the cycle after the issue cycle

Behaviour:
- Reset (async, i_rst_n = 0), all outputs:
  - state = IDLE
  - o_req_ready = 1
  - o_rsp_valid = 0, o_rsp_err = 0, o_rsp_rd_data = 0
  - o_data_write = 0, o_data_read = 1, o_data_size = 0, o_data_addr = 0, o_data_wr_data = 0
  - Reset mid-operation abandons the request: no write is issued after reset deasserts and no response is produced.
- IDLE:
  - o_req_ready = 1.
  - On i_req_valid, the request (write, funct3, addr, wr_data) is captured.
  - Error check: misaligned when H/HU has addr[0] = 1, or W has addr[1:0] != 0; out of range when upper address bits are nonzero.
  - Unsupported funct3 values (011, 110, 111) are treated as errors.
  - Error -> RESP. No error -> ISSUE.
- ISSUE (one cycle), memory outputs driven from the captured registers:
  - o_data_addr = {addr[31:2], 2'b00}.
  - Mask: B = 4'b0001 << addr[1:0]; H = 4'b0011 << {addr[1], 1'b0}; W = 4'b1111. The mask is driven for loads too.
  - Store: o_data_write = 1, o_data_read = 0, o_data_wr_data = {4{b}} for B, {2{h}} for H, word for W.
  - Load: o_data_write = 0, o_data_read = 1.
  - Next state is RESP.
- RESP (one cycle):
  - o_rsp_valid = 1.
  - Load without error: lane = i_data_rd_data >> (addr[1:0]*8). B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W is passed through.
  - o_rsp_err as computed in IDLE.
  - Next state is IDLE.
  - Outside RESP, o_rsp_valid = 0 and o_rsp_rd_data = 0.
- Latency, accept cycle A:
  - Valid access: response at A+2.
  - Error: response at A+1.
  - Next accept no earlier than the cycle after RESP.
- Memory outputs outside ISSUE: o_data_write = 0, o_data_read = 1, o_data_size = 0.
- There is no response back-pressure; the core samples o_rsp_* in the o_rsp_valid cycle.
- i_req_valid while not ready is ignored; the core holds its request until accepted.

Optional Feature:
- Macro: LSU_RSP_REG_EN
- Defined: the extracted load data and error flag are registered, so RESP is followed by an extra RESP2 state. o_rsp_valid and data appear one cycle later: A+3 for valid accesses, A+2 for errors. Outputs come straight from flops.
- Undefined: the RESP output is combinational from i_data_rd_data, as described above.

Test Plan:
- Store SW addr 0x100, data 0xDEADBEEF -> ISSUE: o_data_addr 0x100, size 4'b1111, write 1, read 0; o_rsp_valid at A+2, err 0.
- Store SB addr 0x203, data 0x000000A5 -> size 4'b1000, wr_data 0xA5A5A5A5, o_data_addr 0x200.
- Load LB addr 0x202, memory word 0x12F45678 -> o_rsp_rd_data 0xFFFFFFF4. LBU at the same address -> 0x000000F4. LH addr 0x202 -> 0x000012F4.
- LW addr 0x102 -> no write or read issue; o_rsp_valid at A+1 with err 1, data 0. LW addr 0x1000 (out of range) -> same response.
- Back-to-back requests held valid -> o_req_ready low in ISSUE and RESP, second accept at A+3, no request lost or duplicated.
- i_rst_n pulsed low during ISSUE of a store -> o_data_write 0 immediately, no o_rsp_valid, o_req_ready 1 after release.
